// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: two-requester round-robin front end for one shared,
// non-pipelined double-precision multiplier. One operation is in flight at a
// time: the accepted pair is loaded, run for EXEC_CYCLES compute cycles,
// captured, and held on the response port until the consumer takes it.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/req1_valid           requester N presents an operand pair
//   req0_ready/req1_ready           requester N accepted this cycle (combinational)
//   req0_a/req0_b, req1_a/req1_b    64-bit IEEE-754 double operands
//   rsp_valid/rsp_ready             product handshake
//   rsp_id                          owner of rsp_result
//   rsp_result                      64-bit product
//   mul_en/mul_load/mul_rst         shared multiplier controls
//   mul_a/mul_b                     multiplier operands
//   mul_result                      multiplier result register
//
// Optional feature: define FPMUL_ARB_ZERO_BYPASS_EN to answer pairs with a
// zero operand (signed zero) directly, without using the multiplier.

`timescale 1ns/1ps

module fpmul_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        mul_en,
    output logic        mul_load,
    output logic        mul_rst,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    input  logic [63:0] mul_result
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EXEC = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_id_q, rsp_id_d;
    logic                mul_en_q, mul_en_d;
    logic                mul_load_q, mul_load_d;
    logic                mul_rst_q;

    // Round-robin grant; last_q=1 means req1 was granted last, so req0 wins a tie.
    logic              gnt1;
    logic              accept;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    assign gnt1   = req1_valid && (!req0_valid || !last_q);
    // No acceptance while the multiplier is still being held in reset.
    assign accept = (state_q == IDLE) && !mul_rst_q && (req0_valid || req1_valid);
    assign sel_a  = gnt1 ? req1_a : req0_a;
    assign sel_b  = gnt1 ? req1_b : req0_b;

    assign req0_ready = accept && !gnt1;
    assign req1_ready = accept && gnt1;

`ifdef FPMUL_ARB_ZERO_BYPASS_EN
    logic sel_zero;
    assign sel_zero = (sel_a[DATA_W-2:0] == '0) || (sel_b[DATA_W-2:0] == '0);
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d = sel_a;
                    op_b_d = sel_b;
                    id_d   = gnt1;
                    last_d = gnt1;
                    cnt_d  = '0;
`ifdef FPMUL_ARB_ZERO_BYPASS_EN
                    if (sel_zero) begin
                        state_d = RESP;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = CAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAP: begin
                rsp_result_d = mul_result;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
`ifdef FPMUL_ARB_ZERO_BYPASS_EN
                // Bypassed pairs arrive here with no response yet: form the signed zero.
                if (!rsp_valid_q) begin
                    rsp_result_d = {op_a_q[DATA_W-1] ^ op_b_q[DATA_W-1], (DATA_W-1)'(0)};
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
`else
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Multiplier controls are registered, so decode them from the next state.
        mul_en_d   = (state_d == LOAD) || (state_d == EXEC);
        mul_load_d = (state_d == LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            mul_en_q     <= 1'b0;
            mul_load_q   <= 1'b0;
            mul_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            mul_en_q     <= mul_en_d;
            mul_load_q   <= mul_load_d;
            mul_rst_q    <= 1'b0;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign mul_en     = mul_en_q;
    assign mul_load   = mul_load_q;
    assign mul_rst    = mul_rst_q;
    assign mul_a      = op_a_q;
    assign mul_b      = op_b_q;

endmodule

// File: doc/fpmul_arbiter.md
FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1: number of multiplier compute cycles (en=1, load=0) per operation; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operand pair.
REQ-005 req0_ready / req1_ready  output  1  requester N's operand pair is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  64  IEEE-754 double operands of requester N.
REQ-007 rsp_valid  output  1  product available.
REQ-008 rsp_ready  input  1  consumer takes the product.
REQ-009 rsp_id  output  1  index of the requester that owns rsp_result.
REQ-010 rsp_result  output  64  product.
REQ-011 mul_en, mul_load, mul_rst  output  1  drive the shared multiplier's en, load and synchronous active-high rst.
REQ-012 mul_a, mul_b  output  64  multiplier operand inputs.
REQ-013 mul_result  input  64  multiplier result register.

Function
REQ-014 Shall use a FSM with states IDLE, LOAD, EXEC, CAP and RESP, and process one operation at a time, with no pipelining.
REQ-015 IDLE: when any reqN_valid=1, shall grant round-robin, raising reqN_ready combinationally for the granted requester only; on that edge it shall register the operands and id, then go to LOAD.
REQ-016 Round-robin rule: a requester that is the only one valid shall be granted; when both are valid, the requester not granted last shall be granted; last-grant pointer shall update only on acceptance.
REQ-017 reqN_ready shall be 0 in every state except IDLE.
REQ-018 LOAD (1 cycle): mul_en=1, mul_load=1, mul_a/mul_b = registered operands; then go to EXEC.
REQ-019 EXEC (EXEC_CYCLES cycles, counted by a 4-bit counter): mul_en=1, mul_load=0; then go to CAP.
REQ-020 CAP (1 cycle): rsp_result <= mul_result, rsp_id <= registered id, rsp_valid <= 1; then go to RESP.
REQ-021 RESP: rsp_valid, rsp_result and rsp_id shall be held stable until rsp_ready=1; on that edge, rsp_valid <= 0 and the FSM goes to IDLE.
REQ-022 Latency with EXEC_CYCLES=1: rsp_valid shall rise 3 edges after the acceptance edge; in general, the latency is EXEC_CYCLES+2 edges.
REQ-023 mul_en=0 and mul_load=0 in IDLE, CAP and RESP; mul_a and mul_b shall hold the last registered operands.
REQ-024 A new request in the same cycle as the rsp handshake shall not be accepted before the FSM is back in IDLE (earliest: the next cycle).
REQ-025 A deasserted reqN_valid in IDLE without a handshake shall leave the state and pointer unchanged.

Reset
REQ-026 rst_n low shall asynchronously force: state=IDLE, rsp_valid=0, rsp_result=0, rsp_id=0, last-grant pointer=1 (req0 wins first), counter=0, operand registers=0, mul_en=0, mul_load=0, mul_rst=1.
REQ-027 mul_rst shall deassert on the first clk edge after rst_n rises; no request shall be accepted in that cycle.
REQ-028 Reset mid-operation shall abandon the operation; no rsp_valid shall be produced for it.

Configuration
REQ-029 Macro FPMUL_ARB_ZERO_BYPASS_EN: when defined, an accepted pair with a[62:0]==0 or b[62:0]==0 shall skip LOAD, EXEC and CAP: the FSM goes IDLE->RESP with rsp_result={a[63]^b[63], 63'b0} and rsp_valid rising 1 edge after acceptance; mul_en shall stay 0.
REQ-030 When the macro is undefined, all pairs shall go through the multiplier unchanged, including zeros.

Verification
REQ-031 Basic: req0 a=0x4000000000000000, b=0x4008000000000000 -> rsp_result=0x4018000000000000, rsp_id=0, rsp_valid 3 edges after acceptance.
REQ-032 Contention: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_result stable, both reqN_ready=0, mul_en=0; released on the first rsp_ready=1 edge.
REQ-034 Reset in EXEC: rst_n pulled low mid-operation -> all outputs at reset values immediately, mul_rst=1, no response ever for that operation.
REQ-035 With FPMUL_ARB_ZERO_BYPASS_EN: a=0x8000000000000000, b=0x3FF0000000000000 -> rsp_result=0x8000000000000000 one edge after acceptance, mul_en never high; without the macro: latency 3.
REQ-036 EXEC_CYCLES=4: 2.0*3.0 -> same result, rsp_valid 6 edges after acceptance, mul_en high for exactly 5 cycles.
